// File: rtl/mul_pkg.sv
// Shared op encodings, FSM state type and op-decoding helpers for the
// iterative multiply / multiply-accumulate unit.
package mul_pkg;

  localparam logic [2:0] OP_MUL   = 3'd0;
  localparam logic [2:0] OP_MLA   = 3'd1;
  localparam logic [2:0] OP_UMULL = 3'd4;
  localparam logic [2:0] OP_UMLAL = 3'd5;
  localparam logic [2:0] OP_SMULL = 3'd6;
  localparam logic [2:0] OP_SMLAL = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Codes 2 and 3 are undefined; they decode as plain MUL (short, unsigned, no acc).
  function automatic logic is_long(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic is_signed(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

  function automatic logic is_acc(input logic [2:0] op);
    return (op == OP_MLA) || (op == OP_UMLAL) || (op == OP_SMLAL);
  endfunction

endpackage

// File: rtl/mul_step.sv
// One iteration of the radix-2^BITS_PER_CYCLE multiplier: adds the partial
// product of a multiplier chunk and the (pre-shifted) multiplicand to the sum.
module mul_step #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic [BITS_PER_CYCLE-1:0] chunk,
  input  logic [2*WIDTH-1:0]        mcand,
  input  logic [2*WIDTH-1:0]        sum,
  input  logic                      neg_msb,
  output logic [2*WIDTH-1:0]        sum_next
);

  logic [2*WIDTH-1:0] acc;

  // In signed mode the top bit of the final chunk is the multiplier sign bit,
  // so its partial product is subtracted rather than added.
  always_comb begin
    acc = sum;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      if (chunk[j]) begin
        if (neg_msb && (j == BITS_PER_CYCLE - 1))
          acc = acc - (mcand << j);
        else
          acc = acc + (mcand << j);
      end
    end
    sum_next = acc;
  end

endmodule

// File: rtl/mul_acc_unit.sv
// Multi-cycle MUL/MLA/UMULL/UMLAL/SMULL/SMLAL unit with valid/ready issue,
// fixed latency of WIDTH/BITS_PER_CYCLE + 1 cycles, and synchronous flush.
import mul_pkg::*;

module mul_acc_unit #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] acc_hi,
  output logic             out_valid,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi,
  output logic             flag_n,
  output logic             flag_z
);

  localparam int N     = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int W2    = 2 * WIDTH;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [W2-1:0]       mcand;
  logic [W2-1:0]       sum;
  logic [W2-1:0]       sum_next;
  logic [W2-1:0]       acc_init;
  logic [W2-1:0]       mcand_init;
  logic [WIDTH-1:0]    mplier;
  logic                long_q;
  logic                signed_q;
  logic                accept;
  logic                last;
  logic [WIDTH-1:0]    res_lo_d;
  logic [WIDTH-1:0]    res_hi_d;
  logic                flag_n_d;
  logic                flag_z_d;

  assign in_ready = (state == IDLE) || (state == DONE);
  assign accept   = in_valid & in_ready & ~flush;
  assign last     = (cnt == CNT_W'(N - 1));

  always_comb begin
    acc_init = '0;
    if (is_acc(op))
      acc_init = is_long(op) ? {acc_hi, acc_lo} : {{WIDTH{1'b0}}, acc_lo};
    mcand_init = is_signed(op) ? {{WIDTH{op_a[WIDTH-1]}}, op_a}
                               : {{WIDTH{1'b0}}, op_a};
  end

  mul_step #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .chunk    (mplier[BITS_PER_CYCLE-1:0]),
    .mcand    (mcand),
    .sum      (sum),
    .neg_msb  (signed_q & last),
    .sum_next (sum_next)
  );

  // Short ops report only the low word; the high word reads as zero.
  always_comb begin
    res_lo_d = sum_next[WIDTH-1:0];
    res_hi_d = long_q ? sum_next[W2-1:WIDTH] : '0;
    flag_n_d = long_q ? sum_next[W2-1] : sum_next[WIDTH-1];
    flag_z_d = long_q ? (sum_next == '0) : (sum_next[WIDTH-1:0] == '0);
  end

  // Operand and shift registers: no reset, they are qualified by the FSM.
  always_ff @(posedge clk) begin
    if (accept) begin
      mcand    <= mcand_init;
      mplier   <= op_b;
      sum      <= acc_init;
      long_q   <= is_long(op);
      signed_q <= is_signed(op);
    end else if (state == RUN) begin
      sum    <= sum_next;
      mcand  <= mcand << BITS_PER_CYCLE;
      mplier <= mplier >> BITS_PER_CYCLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      res_lo    <= '0;
      res_hi    <= '0;
      flag_n    <= 1'b0;
      flag_z    <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          out_valid <= 1'b0;
          cnt       <= '0;
          if (accept) state <= RUN;
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (last) begin
            state     <= DONE;
            out_valid <= 1'b1;
            res_lo    <= res_lo_d;
            res_hi    <= res_hi_d;
            flag_n    <= flag_n_d;
            flag_z    <= flag_z_d;
          end
        end
        DONE: begin
          out_valid <= 1'b0;
          cnt       <= '0;
          state     <= accept ? RUN : IDLE;
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_acc_unit.sv
// Directed bench for mul_acc_unit (WIDTH=32, BITS_PER_CYCLE=2).
module tb_mul_acc_unit;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [31:0] op_a, op_b, acc_lo, acc_hi;
  logic        out_valid;
  logic [31:0] res_lo, res_hi;
  logic        flag_n, flag_z;

  int nc;
  int nf;

  mul_acc_unit #(.WIDTH(32), .BITS_PER_CYCLE(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .op_a      (op_a),
    .op_b      (op_b),
    .acc_lo    (acc_lo),
    .acc_hi    (acc_hi),
    .out_valid (out_valid),
    .res_lo    (res_lo),
    .res_hi    (res_hi),
    .flag_n    (flag_n),
    .flag_z    (flag_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic start_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] lo, input logic [31:0] hi);
    @(negedge clk);
    op = o; op_a = a; op_b = b; acc_lo = lo; acc_hi = hi;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    nc++; if (in_ready !== 1'b1) begin nf++; $display("FAIL rst_ready got %b exp 1", in_ready); end
    nc++; if (out_valid !== 1'b0) begin nf++; $display("FAIL rst_valid got %b exp 0", out_valid); end
    nc++; if (res_lo !== 32'h0) begin nf++; $display("FAIL rst_lo got %h exp 0", res_lo); end
    nc++; if (res_hi !== 32'h0) begin nf++; $display("FAIL rst_hi got %h exp 0", res_hi); end
    nc++; if ({flag_n, flag_z} !== 2'b00) begin nf++; $display("FAIL rst_flags got %b exp 00", {flag_n, flag_z}); end
  endtask

  task automatic test_umull;
    int lat;
    start_op(3'd4, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0);
    wait_done(lat);
    nc++; if (lat !== 17) begin nf++; $display("FAIL umull_latency got %0d exp 17", lat); end
    nc++; if (res_hi !== 32'hFFFFFFFE) begin nf++; $display("FAIL umull_hi got %h exp fffffffe", res_hi); end
    nc++; if (res_lo !== 32'h00000001) begin nf++; $display("FAIL umull_lo got %h exp 00000001", res_lo); end
    nc++; if ({flag_n, flag_z} !== 2'b10) begin nf++; $display("FAIL umull_flags got %b exp 10", {flag_n, flag_z}); end
    @(negedge clk);
    nc++; if (out_valid !== 1'b0) begin nf++; $display("FAIL umull_pulse got %b exp 0", out_valid); end
    nc++; if (res_hi !== 32'hFFFFFFFE) begin nf++; $display("FAIL umull_hold got %h exp fffffffe", res_hi); end
  endtask

  task automatic test_smull;
    int lat;
    start_op(3'd6, 32'h80000000, 32'h00000002, 32'h0, 32'h0);
    wait_done(lat);
    nc++; if (lat !== 17) begin nf++; $display("FAIL smull1_latency got %0d exp 17", lat); end
    nc++; if (res_hi !== 32'hFFFFFFFF) begin nf++; $display("FAIL smull1_hi got %h exp ffffffff", res_hi); end
    nc++; if (res_lo !== 32'h0) begin nf++; $display("FAIL smull1_lo got %h exp 0", res_lo); end
    nc++; if ({flag_n, flag_z} !== 2'b10) begin nf++; $display("FAIL smull1_flags got %b exp 10", {flag_n, flag_z}); end
    start_op(3'd6, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0);
    wait_done(lat);
    nc++; if (res_hi !== 32'h0) begin nf++; $display("FAIL smull2_hi got %h exp 0", res_hi); end
    nc++; if (res_lo !== 32'h1) begin nf++; $display("FAIL smull2_lo got %h exp 1", res_lo); end
    nc++; if ({flag_n, flag_z} !== 2'b00) begin nf++; $display("FAIL smull2_flags got %b exp 00", {flag_n, flag_z}); end
  endtask

  task automatic test_accumulate;
    int lat;
    start_op(3'd1, 32'h3, 32'h4, 32'hFFFFFFF4, 32'h12345678);
    wait_done(lat);
    nc++; if (res_lo !== 32'h0) begin nf++; $display("FAIL mla_lo got %h exp 0", res_lo); end
    nc++; if (res_hi !== 32'h0) begin nf++; $display("FAIL mla_hi got %h exp 0", res_hi); end
    nc++; if ({flag_n, flag_z} !== 2'b01) begin nf++; $display("FAIL mla_flags got %b exp 01", {flag_n, flag_z}); end
    start_op(3'd5, 32'hFFFFFFFF, 32'h1, 32'h00000001, 32'hFFFFFFFF);
    wait_done(lat);
    nc++; if ({res_hi, res_lo} !== 64'h0) begin nf++; $display("FAIL umlal_res got %h exp 0", {res_hi, res_lo}); end
    nc++; if ({flag_n, flag_z} !== 2'b01) begin nf++; $display("FAIL umlal_flags got %b exp 01", {flag_n, flag_z}); end
    // Undefined code 3 behaves as MUL: accumulator ignored, high word zero.
    start_op(3'd3, 32'h7, 32'h6, 32'd100, 32'h1);
    wait_done(lat);
    nc++; if (res_lo !== 32'd42) begin nf++; $display("FAIL illegal_lo got %h exp 2a", res_lo); end
    nc++; if (res_hi !== 32'h0) begin nf++; $display("FAIL illegal_hi got %h exp 0", res_hi); end
  endtask

  task automatic test_back_to_back;
    int lat;
    logic bad;
    bad = 1'b0;
    @(negedge clk);
    op = 3'd4; op_a = 32'd5; op_b = 32'd7; acc_lo = 32'h0; acc_hi = 32'h0;
    in_valid = 1'b1;
    @(posedge clk);
    #1 op = 3'd6; op_a = 32'hFFFFFFFD; op_b = 32'd4; acc_lo = 32'h55; acc_hi = 32'h66;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (in_ready !== 1'b0 || out_valid !== 1'b0) bad = 1'b1;
    end
    nc++; if (bad !== 1'b0) begin nf++; $display("FAIL b2b_run_busy got %b exp 0", bad); end
    @(negedge clk);
    nc++; if ({out_valid, in_ready} !== 2'b11) begin nf++; $display("FAIL b2b_done got %b exp 11", {out_valid, in_ready}); end
    nc++; if (res_lo !== 32'd35) begin nf++; $display("FAIL b2b_first_lo got %h exp 23", res_lo); end
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_done(lat);
    nc++; if (lat !== 17) begin nf++; $display("FAIL b2b_latency got %0d exp 17", lat); end
    nc++; if ({res_hi, res_lo} !== 64'hFFFFFFFF_FFFFFFF4) begin nf++; $display("FAIL b2b_second got %h exp fffffffffffffff4", {res_hi, res_lo}); end
    nc++; if (flag_n !== 1'b1) begin nf++; $display("FAIL b2b_n got %b exp 1", flag_n); end
  endtask

  task automatic test_flush;
    int lat;
    logic seen;
    seen = 1'b0;
    start_op(3'd4, 32'h1234, 32'h10, 32'h0, 32'h0);
    repeat (8) @(negedge clk);
    flush = 1'b1; in_valid = 1'b1;
    op = 3'd4; op_a = 32'd9; op_b = 32'd9;
    @(posedge clk);
    #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    nc++; if ({in_ready, out_valid} !== 2'b10) begin nf++; $display("FAIL flush_ctrl got %b exp 10", {in_ready, out_valid}); end
    nc++; if ({res_hi, res_lo} !== 64'hFFFFFFFF_FFFFFFF4) begin nf++; $display("FAIL flush_hold got %h exp fffffffffffffff4", {res_hi, res_lo}); end
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    nc++; if (seen !== 1'b0) begin nf++; $display("FAIL flush_no_valid got %b exp 0", seen); end
    start_op(3'd5, 32'h10000, 32'h10000, 32'h00000002, 32'h00000001);
    wait_done(lat);
    nc++; if (lat !== 17) begin nf++; $display("FAIL flush_after_latency got %0d exp 17", lat); end
    nc++; if ({res_hi, res_lo} !== 64'h00000002_00000002) begin nf++; $display("FAIL flush_after_res got %h exp 0000000200000002", {res_hi, res_lo}); end
  endtask

  task automatic test_reset_mid;
    logic seen;
    seen = 1'b0;
    start_op(3'd7, 32'h3, 32'h5, 32'h1, 32'h0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    nc++; if ({in_ready, out_valid} !== 2'b10) begin nf++; $display("FAIL rstmid_ctrl got %b exp 10", {in_ready, out_valid}); end
    nc++; if ({res_hi, res_lo} !== 64'h0) begin nf++; $display("FAIL rstmid_res got %h exp 0", {res_hi, res_lo}); end
    nc++; if ({flag_n, flag_z} !== 2'b00) begin nf++; $display("FAIL rstmid_flags got %b exp 00", {flag_n, flag_z}); end
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    nc++; if (seen !== 1'b0) begin nf++; $display("FAIL rstmid_no_valid got %b exp 0", seen); end
  endtask

  initial begin
    nc = 0; nf = 0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
    op = 3'd0; op_a = '0; op_b = '0; acc_lo = '0; acc_hi = '0;
    test_reset();
    test_umull();
    test_smull();
    test_accumulate();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nc, nf);
    $finish;
  end

endmodule
